// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_if
//  Purpose  : Producer handshakes (ALU, LSB) and the registered CDB broadcast
//             shared between the result producers, the arbiter and snoopers.
//  Revision : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4
);

  // ALU result port (source 0)
  logic                    alu_valid;
  logic                    alu_ready;
  logic [ROB_ID_WIDTH-1:0] alu_rob_id;
  logic [DATA_WIDTH-1:0]   alu_value;
  logic                    alu_jump;
  logic [DATA_WIDTH-1:0]   alu_pc_next;

  // Load/store buffer result port (source 1)
  logic                    lsb_valid;
  logic                    lsb_ready;
  logic [ROB_ID_WIDTH-1:0] lsb_rob_id;
  logic [DATA_WIDTH-1:0]   lsb_value;

  // Common data bus broadcast
  logic                    cdb_valid;
  logic                    cdb_src;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id;
  logic [DATA_WIDTH-1:0]   cdb_value;
  logic                    cdb_jump;
  logic [DATA_WIDTH-1:0]   cdb_pc_next;

  // Producer / snooper side
  modport master (
    output alu_valid, alu_rob_id, alu_value, alu_jump, alu_pc_next,
    input  alu_ready,
    output lsb_valid, lsb_rob_id, lsb_value,
    input  lsb_ready,
    input  cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_jump, cdb_pc_next
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rob_id, alu_value, alu_jump, alu_pc_next,
    output alu_ready,
    input  lsb_valid, lsb_rob_id, lsb_value,
    output lsb_ready,
    output cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_jump, cdb_pc_next
  );

endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Two small per-source result FIFOs (ALU, LSB) drained one entry
//             per cycle by a round-robin arbiter onto a registered CDB.
//             A mispredict empties both FIFOs; rdy low freezes everything.
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int FIFO_DEPTH   = 2    // power of two, at least 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,        // asynchronous, active low
  input  wire logic       rdy_i,        // global enable
  input  wire logic       mispredict_i, // synchronous flush
  cdb_arbiter_if.slave    bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Grant encoding for the round-robin pointer
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_LSB = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // ALU FIFO storage and control
  logic [ROB_ID_WIDTH-1:0] alu_rob_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   alu_val_mem_q [FIFO_DEPTH];
  logic                    alu_jmp_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   alu_pc_mem_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]        alu_head_q, alu_head_d;
  logic [PTR_W-1:0]        alu_tail_q, alu_tail_d;
  logic [CNT_W-1:0]        alu_cnt_q,  alu_cnt_d;

  // LSB FIFO storage and control (jump/pc_next are always zero for LSB)
  logic [ROB_ID_WIDTH-1:0] lsb_rob_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   lsb_val_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        lsb_head_q, lsb_head_d;
  logic [PTR_W-1:0]        lsb_tail_q, lsb_tail_d;
  logic [CNT_W-1:0]        lsb_cnt_q,  lsb_cnt_d;

  // Round-robin pointer: source granted at the last contended pop
  logic                    last_grant_q, last_grant_d;

  // Registered broadcast
  logic                    cdb_valid_q,   cdb_valid_d;
  logic                    cdb_src_q,     cdb_src_d;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id_q,  cdb_rob_id_d;
  logic [DATA_WIDTH-1:0]   cdb_value_q,   cdb_value_d;
  logic                    cdb_jump_q,    cdb_jump_d;
  logic [DATA_WIDTH-1:0]   cdb_pc_next_q, cdb_pc_next_d;

  // --------------------------------------------------------------------------
  // Handshake and arbitration decode
  // --------------------------------------------------------------------------
  logic advance;      // normal operating cycle: enabled and not flushing
  logic flush;        // enabled flush cycle
  logic alu_ready, lsb_ready;
  logic alu_push,  lsb_push;
  logic alu_ne,    lsb_ne;
  logic alu_pop,   lsb_pop;
  logic contended;

  assign advance = rdy_i & ~mispredict_i;
  assign flush   = rdy_i &  mispredict_i;

  // Readiness looks only at the registered count, so a full FIFO refuses a
  // push even in a cycle where it is also being popped. Held low in reset.
  assign alu_ready = rst_n & advance & (alu_cnt_q < DEPTH_C);
  assign lsb_ready = rst_n & advance & (lsb_cnt_q < DEPTH_C);

  assign alu_push  = bus.alu_valid & alu_ready;
  assign lsb_push  = bus.lsb_valid & lsb_ready;

  assign alu_ne    = (alu_cnt_q != '0);
  assign lsb_ne    = (lsb_cnt_q != '0);
  assign contended = alu_ne & lsb_ne;

  // On contention the source that did not win last time is served; a lone
  // non-empty source is always served.
  assign alu_pop = advance & alu_ne & (~lsb_ne | (last_grant_q == GNT_LSB));
  assign lsb_pop = advance & lsb_ne & (~alu_ne | (last_grant_q == GNT_ALU));

  // --------------------------------------------------------------------------
  // Next-state: FIFO pointers/counts and round-robin pointer
  // --------------------------------------------------------------------------
  // Flush clears both queues; otherwise push/pop move tail/head independently.
  always_comb begin
    alu_head_d   = alu_head_q;
    alu_tail_d   = alu_tail_q;
    alu_cnt_d    = alu_cnt_q;
    lsb_head_d   = lsb_head_q;
    lsb_tail_d   = lsb_tail_q;
    lsb_cnt_d    = lsb_cnt_q;
    last_grant_d = last_grant_q;

    if (flush) begin
      alu_head_d = '0;
      alu_tail_d = '0;
      alu_cnt_d  = '0;
      lsb_head_d = '0;
      lsb_tail_d = '0;
      lsb_cnt_d  = '0;
    end else if (advance) begin
      if (alu_push) alu_tail_d = alu_tail_q + PTR_W'(1);
      if (alu_pop)  alu_head_d = alu_head_q + PTR_W'(1);
      alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(alu_pop);

      if (lsb_push) lsb_tail_d = lsb_tail_q + PTR_W'(1);
      if (lsb_pop)  lsb_head_d = lsb_head_q + PTR_W'(1);
      lsb_cnt_d = lsb_cnt_q + CNT_W'(lsb_push) - CNT_W'(lsb_pop);

      // The pointer only moves when both sources competed, so an
      // uncontended pop does not change who wins the next tie.
      if (contended) last_grant_d = lsb_pop ? GNT_LSB : GNT_ALU;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: CDB broadcast register
  // --------------------------------------------------------------------------
  // Popped head goes onto the bus; an idle or flush cycle only drops valid.
  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_src_d     = cdb_src_q;
    cdb_rob_id_d  = cdb_rob_id_q;
    cdb_value_d   = cdb_value_q;
    cdb_jump_d    = cdb_jump_q;
    cdb_pc_next_d = cdb_pc_next_q;

    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (advance) begin
      if (alu_pop) begin
        cdb_valid_d   = 1'b1;
        cdb_src_d     = GNT_ALU;
        cdb_rob_id_d  = alu_rob_mem_q[alu_head_q];
        cdb_value_d   = alu_val_mem_q[alu_head_q];
        cdb_jump_d    = alu_jmp_mem_q[alu_head_q];
        cdb_pc_next_d = alu_pc_mem_q[alu_head_q];
      end else if (lsb_pop) begin
        cdb_valid_d   = 1'b1;
        cdb_src_d     = GNT_LSB;
        cdb_rob_id_d  = lsb_rob_mem_q[lsb_head_q];
        cdb_value_d   = lsb_val_mem_q[lsb_head_q];
        cdb_jump_d    = 1'b0;
        cdb_pc_next_d = '0;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  // Control and broadcast registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_head_q    <= '0;
      alu_tail_q    <= '0;
      alu_cnt_q     <= '0;
      lsb_head_q    <= '0;
      lsb_tail_q    <= '0;
      lsb_cnt_q     <= '0;
      last_grant_q  <= GNT_LSB;   // ALU wins the first tie
      cdb_valid_q   <= 1'b0;
      cdb_src_q     <= 1'b0;
      cdb_rob_id_q  <= '0;
      cdb_value_q   <= '0;
      cdb_jump_q    <= 1'b0;
      cdb_pc_next_q <= '0;
    end else begin
      alu_head_q    <= alu_head_d;
      alu_tail_q    <= alu_tail_d;
      alu_cnt_q     <= alu_cnt_d;
      lsb_head_q    <= lsb_head_d;
      lsb_tail_q    <= lsb_tail_d;
      lsb_cnt_q     <= lsb_cnt_d;
      last_grant_q  <= last_grant_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_src_q     <= cdb_src_d;
      cdb_rob_id_q  <= cdb_rob_id_d;
      cdb_value_q   <= cdb_value_d;
      cdb_jump_q    <= cdb_jump_d;
      cdb_pc_next_q <= cdb_pc_next_d;
    end
  end

  // ALU payload storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_rob_mem_q[alu_tail_q] <= bus.alu_rob_id;
      alu_val_mem_q[alu_tail_q] <= bus.alu_value;
      alu_jmp_mem_q[alu_tail_q] <= bus.alu_jump;
      alu_pc_mem_q[alu_tail_q]  <= bus.alu_pc_next;
    end
  end

  // LSB payload storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (lsb_push) begin
      lsb_rob_mem_q[lsb_tail_q] <= bus.lsb_rob_id;
      lsb_val_mem_q[lsb_tail_q] <= bus.lsb_value;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.alu_ready   = alu_ready;
  assign bus.lsb_ready   = lsb_ready;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_src     = cdb_src_q;
  assign bus.cdb_rob_id  = cdb_rob_id_q;
  assign bus.cdb_value   = cdb_value_q;
  assign bus.cdb_jump    = cdb_jump_q;
  assign bus.cdb_pc_next = cdb_pc_next_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Directed self-checking bench for cdb_arbiter: reset, single
//             push latency, interleaving, backpressure, flush, stall and
//             asynchronous reset mid-operation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic clk;
  logic rst_n;
  logic rdy;
  logic mispredict;

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter_if #(.DATA_WIDTH(32), .ROB_ID_WIDTH(4)) bus ();

  cdb_arbiter #(
    .DATA_WIDTH  (32),
    .ROB_ID_WIDTH(4),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy_i       (rdy),
    .mispredict_i(mispredict),
    .bus         (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle 1 ns before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks valid and, when a broadcast is expected, its source and tag
  task automatic cdb_chk(input string tag, input logic v, input logic src, input logic [3:0] rob);
    chk1({tag, "_valid"}, bus.cdb_valid, v);
    if (v) begin
      chk1({tag, "_src"}, bus.cdb_src, src);
      chk4({tag, "_rob"}, bus.cdb_rob_id, rob);
    end
  endtask

  task automatic set_alu(input logic v, input logic [3:0] id, input logic [31:0] val,
                         input logic j, input logic [31:0] pc);
    bus.alu_valid   = v;
    bus.alu_rob_id  = id;
    bus.alu_value   = val;
    bus.alu_jump    = j;
    bus.alu_pc_next = pc;
  endtask

  task automatic set_lsb(input logic v, input logic [3:0] id, input logic [31:0] val);
    bus.lsb_valid  = v;
    bus.lsb_rob_id = id;
    bus.lsb_value  = val;
  endtask

  initial begin
    rst_n      = 1'b0;
    rdy        = 1'b1;
    mispredict = 1'b0;
    set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    set_lsb(1'b0, 4'd0, 32'h0);

    // ---------------- Reset ----------------
    repeat (3) tick();
    chk1("rst_alu_ready", bus.alu_ready, 1'b0);
    chk1("rst_lsb_ready", bus.lsb_ready, 1'b0);
    chk1("rst_cdb_valid", bus.cdb_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("post_rst_alu_ready", bus.alu_ready, 1'b1);
    chk1("post_rst_lsb_ready", bus.lsb_ready, 1'b1);
    chk1("post_rst_cdb_valid", bus.cdb_valid, 1'b0);
    chk32("post_rst_cdb_value", bus.cdb_value, 32'h0);
    chk32("post_rst_cdb_pc", bus.cdb_pc_next, 32'h0);

    // ---------------- Single ALU push ----------------
    set_alu(1'b1, 4'd3, 32'h12345678, 1'b1, 32'h1004);
    tick();                                   // edge N: handshake
    set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    chk1("single_no_bypass", bus.cdb_valid, 1'b0);
    tick();                                   // edge N+1: broadcast
    cdb_chk("single", 1'b1, 1'b0, 4'd3);
    chk32("single_value", bus.cdb_value, 32'h12345678);
    chk1("single_jump", bus.cdb_jump, 1'b1);
    chk32("single_pc", bus.cdb_pc_next, 32'h1004);
    tick();                                   // edge N+2: idle
    chk1("single_drop_valid", bus.cdb_valid, 1'b0);
    chk32("single_value_hold", bus.cdb_value, 32'h12345678);

    // ---------------- Simultaneous streams ----------------
    set_alu(1'b1, 4'd1, 32'h000000A1, 1'b0, 32'h0);
    set_lsb(1'b1, 4'd9, 32'h000000B9);
    tick();
    set_alu(1'b1, 4'd2, 32'h000000A2, 1'b1, 32'h2000);
    set_lsb(1'b1, 4'd10, 32'h000000BA);
    tick();
    set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    set_lsb(1'b0, 4'd0, 32'h0);
    cdb_chk("stream0", 1'b1, 1'b0, 4'd1);
    chk32("stream0_value", bus.cdb_value, 32'h000000A1);
    tick();
    cdb_chk("stream1", 1'b1, 1'b1, 4'd9);
    chk32("stream1_value", bus.cdb_value, 32'h000000B9);
    chk1("stream1_jump", bus.cdb_jump, 1'b0);
    chk32("stream1_pc", bus.cdb_pc_next, 32'h0);
    tick();
    cdb_chk("stream2", 1'b1, 1'b0, 4'd2);
    chk1("stream2_jump", bus.cdb_jump, 1'b1);
    chk32("stream2_pc", bus.cdb_pc_next, 32'h2000);
    tick();
    cdb_chk("stream3", 1'b1, 1'b1, 4'd10);
    tick();
    chk1("stream_end", bus.cdb_valid, 1'b0);

    // ---------------- Backpressure ----------------
    set_alu(1'b1, 4'd11, 32'h11, 1'b0, 32'h0);
    set_lsb(1'b1, 4'd1, 32'h51);
    tick();                                   // e1
    chk1("bp1_valid", bus.cdb_valid, 1'b0);
    chk1("bp1_alu_ready", bus.alu_ready, 1'b1);
    set_alu(1'b1, 4'd12, 32'h12, 1'b0, 32'h0);
    set_lsb(1'b1, 4'd2, 32'h52);
    tick();                                   // e2
    cdb_chk("bp2", 1'b1, 1'b1, 4'd1);
    chk1("bp2_alu_ready", bus.alu_ready, 1'b0);
    chk1("bp2_lsb_ready", bus.lsb_ready, 1'b1);
    set_alu(1'b1, 4'd13, 32'h13, 1'b0, 32'h0); // refused: ALU full
    set_lsb(1'b1, 4'd3, 32'h53);
    tick();                                   // e3
    cdb_chk("bp3", 1'b1, 1'b0, 4'd11);
    chk1("bp3_alu_ready", bus.alu_ready, 1'b1);
    chk1("bp3_lsb_ready", bus.lsb_ready, 1'b0);
    set_lsb(1'b1, 4'd4, 32'h54);              // refused: LSB full
    tick();                                   // e4, ALU 13 accepted
    cdb_chk("bp4", 1'b1, 1'b1, 4'd2);
    chk1("bp4_alu_ready", bus.alu_ready, 1'b0);
    chk1("bp4_lsb_ready", bus.lsb_ready, 1'b1);
    set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    tick();                                   // e5, LSB 4 accepted
    cdb_chk("bp5", 1'b1, 1'b0, 4'd12);
    chk1("bp5_lsb_ready", bus.lsb_ready, 1'b0);
    set_lsb(1'b0, 4'd0, 32'h0);
    tick();
    cdb_chk("bp6", 1'b1, 1'b1, 4'd3);
    tick();
    cdb_chk("bp7", 1'b1, 1'b0, 4'd13);
    chk32("bp7_value", bus.cdb_value, 32'h13);
    tick();
    cdb_chk("bp8", 1'b1, 1'b1, 4'd4);
    tick();
    chk1("bp_end", bus.cdb_valid, 1'b0);

    // ---------------- Flush ----------------
    set_alu(1'b1, 4'd4, 32'h44, 1'b0, 32'h0);
    set_lsb(1'b1, 4'd6, 32'h66);
    tick();                                   // both queued
    chk1("fl_pre_valid", bus.cdb_valid, 1'b0);
    set_lsb(1'b0, 4'd0, 32'h0);
    set_alu(1'b1, 4'd5, 32'h55, 1'b0, 32'h0); // offered during flush
    mispredict = 1'b1;
    #1;
    chk1("fl_alu_ready_low", bus.alu_ready, 1'b0);
    chk1("fl_lsb_ready_low", bus.lsb_ready, 1'b0);
    tick();
    mispredict = 1'b0;
    set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    #1;
    chk1("fl_valid", bus.cdb_valid, 1'b0);
    chk1("fl_alu_ready", bus.alu_ready, 1'b1);
    chk1("fl_lsb_ready", bus.lsb_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("fl_idle_valid", bus.cdb_valid, 1'b0);
    end

    // ---------------- Stall ----------------
    set_alu(1'b1, 4'd1, 32'hC1, 1'b0, 32'h0);
    set_lsb(1'b1, 4'd2, 32'hC2);
    tick();
    set_alu(1'b1, 4'd3, 32'hC3, 1'b0, 32'h0);
    set_lsb(1'b0, 4'd0, 32'h0);
    tick();
    cdb_chk("st_pre", 1'b1, 1'b1, 4'd2);
    rdy = 1'b0;
    set_alu(1'b1, 4'd5, 32'hC5, 1'b0, 32'h0); // must not be accepted
    #1;
    chk1("st_alu_ready", bus.alu_ready, 1'b0);
    chk1("st_lsb_ready", bus.lsb_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      cdb_chk("st_frozen", 1'b1, 1'b1, 4'd2);
      chk32("st_frozen_value", bus.cdb_value, 32'hC2);
    end
    rdy = 1'b1;
    set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    tick();
    cdb_chk("st_resume0", 1'b1, 1'b0, 4'd1);
    chk32("st_resume0_value", bus.cdb_value, 32'hC1);
    tick();
    cdb_chk("st_resume1", 1'b1, 1'b0, 4'd3);
    tick();
    chk1("st_end", bus.cdb_valid, 1'b0);

    // ---------------- Asynchronous reset mid-operation ----------------
    set_alu(1'b1, 4'd8, 32'hD8, 1'b0, 32'h0);
    tick();
    set_alu(1'b1, 4'd9, 32'hD9, 1'b0, 32'h0);
    tick();
    set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    cdb_chk("ar_pre", 1'b1, 1'b0, 4'd8);
    #2;
    rst_n = 1'b0;                             // between clock edges
    #1;
    chk1("ar_valid", bus.cdb_valid, 1'b0);
    chk4("ar_rob", bus.cdb_rob_id, 4'd0);
    chk32("ar_value", bus.cdb_value, 32'h0);
    chk1("ar_alu_ready", bus.alu_ready, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    chk1("ar_lost_entry", bus.cdb_valid, 1'b0);
    // Round-robin pointer back at its reset value: ALU wins the tie
    set_alu(1'b1, 4'd7, 32'hE7, 1'b0, 32'h0);
    set_lsb(1'b1, 4'd14, 32'hEE);
    tick();
    set_alu(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    set_lsb(1'b0, 4'd0, 32'h0);
    tick();
    cdb_chk("ar_tie0", 1'b1, 1'b0, 4'd7);
    tick();
    cdb_chk("ar_tie1", 1'b1, 1'b1, 4'd14);
    tick();
    chk1("ar_end", bus.cdb_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between two result producers: the reservation station's ALU result port (source 0) and the load/store buffer's result port (source 1).
- Each source has a valid/ready handshake into its own small FIFO. A round-robin arbiter pops one entry per cycle into a registered CDB broadcast, which the ROB, RS and LSB all snoop.
- A mispredict flush discards every queued result.

Parameters:
- DATA_WIDTH, 32, width of result value and pc_next
- ROB_ID_WIDTH, 4, width of ROB tag
- FIFO_DEPTH, 2, entries per source FIFO (power of two, at least 2)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rdy  input  1  global enable; low = freeze all state
- mispredict  input  1  synchronous flush from ROB
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU FIFO can accept
- alu_rob_id  input  ROB_ID_WIDTH  tag
- alu_value  input  DATA_WIDTH  result value
- alu_jump  input  1  branch/jump taken
- alu_pc_next  input  DATA_WIDTH  resolved next PC
- lsb_valid  input  1  load/store result offered
- lsb_ready  output  1  LSB FIFO can accept
- lsb_rob_id  input  ROB_ID_WIDTH  tag
- lsb_value  input  DATA_WIDTH  load data (0 for stores)
- cdb_valid  output  1  broadcast valid this cycle
- cdb_src  output  1  0 = ALU, 1 = LSB
- cdb_rob_id  output  ROB_ID_WIDTH  broadcast tag
- cdb_value  output  DATA_WIDTH  broadcast value
- cdb_jump  output  1  broadcast taken flag
- cdb_pc_next  output  DATA_WIDTH  broadcast next PC

Behaviour:
- Reset (rst low, asynchronous):
  - Both FIFOs empty; rr pointer last_grant = 1, so ALU wins the first tie.
  - All cdb_* outputs 0.
  - alu_ready and lsb_ready forced 0 while rst is low.
- Ready:
  - x_ready = rdy && !mispredict && (count_x < FIFO_DEPTH), using the registered count.
  - A full FIFO is not ready even in a cycle where it pops; there is no same-cycle push-through-full.
- Push: at a rising edge with x_valid && x_ready, the payload is written at the tail.
  - LSB entries store jump = 0 and pc_next = 0.
- Arbitration: evaluated each edge with rdy=1 and mispredict=0.
  - Only one FIFO non-empty: pop its head.
  - Both non-empty: pop the source != last_grant, then set last_grant to the popped source.
  - The popped entry is registered onto cdb_* with cdb_valid=1 and cdb_src = that source.
  - Nothing to pop: cdb_valid <= 0; the other cdb_* fields hold their last values.
- Latency: a handshake at edge N puts the entry on the CDB after edge N+1 at the earliest. No bypass path.
- Push and pop on the same FIFO in the same edge are both performed; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
- Fairness: with both sources continuously non-empty, grants strictly alternate. Worst-case wait for a head entry is 1 cycle.
- mispredict=1 at an edge (and rdy=1): both FIFOs are emptied, cdb_valid <= 0, last_grant unchanged.
  - Any push offered that cycle is dropped; ready is already low.
  - Mispredict takes priority over push and pop.
- rdy=0: no pointer, count, grant or output change; cdb outputs hold; readies are low.
- Order within one source is strictly FIFO. No ordering is guaranteed between the two sources.
- Reset asserted mid-operation: immediate asynchronous clear. Queued entries are lost and cdb_valid drops without waiting for a clock.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> cdb_valid=0, cdb_value=0, alu_ready=lsb_ready=1 on the first post-reset cycle with rdy=1.
- Single ALU push (rob_id=3, value=0x12345678, jump=1, pc_next=0x1004) at edge N -> after edge N+1: cdb_valid=1, src=0, rob_id=3, value=0x12345678, jump=1, pc_next=0x1004; after edge N+2: cdb_valid=0.
- Simultaneous streams: push ALU tags 1,2 and LSB tags 9,10 on consecutive edges -> CDB order 1,9,2,10 with src 0,1,0,1, with no idle cycle between them.
- Backpressure:
  - Hold cdb contention with LSB always pending.
  - Push 3 ALU entries back-to-back -> alu_ready low after the 2nd accepted entry until a pop.
  - All 3 tags appear in order with none lost or duplicated.
- Flush: queue ALU tags 4,5 and LSB tag 6, assert mispredict for one edge -> cdb_valid=0 next cycle, both readies return high, and no tag 4/5/6 is ever broadcast afterwards.
- Stall: with entries queued, drop rdy for 4 cycles -> cdb_* frozen and readies low; after rdy returns, broadcasts resume in the same order as without the stall.
